// File: rtl/rysy_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, programmable bit period,
// status/ctrl registers and a level interrupt when the transmitter has drained.
`timescale 1ns/1ps
module rysy_uart_tx #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, busy, ovf;
  logic [15:0]   bauddiv, frame_div, bit_cnt;
  logic          tx_en, irq_en;
  state_t        state;
  logic [2:0]    bit_idx;
  logic [7:0]    tx_byte;
  logic          reg_wr, push_req, push, pop, bit_end, frame_go;
  logic          unused_bits;

  assign full     = (count == (PW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign busy     = (state != IDLE);
  assign reg_wr   = sel & we;
  assign push_req = reg_wr && (addr[3:2] == 2'd0);
  assign push     = push_req & ~full;
  assign bit_end  = (bit_cnt == 16'd1);
  assign frame_go = ~empty & tx_en;
  // A frame starts (and pops) from IDLE, or straight out of a finishing stop bit.
  assign pop      = frame_go && ((state == IDLE) || ((state == STOP) && bit_end));
  assign irq      = irq_en & empty & ~busy;
  assign unused_bits = ^{addr[1:0], wdata[31:16]};

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf     <= 1'b0;
      bauddiv <= DIV_RESET;
      tx_en   <= 1'b1;
      irq_en  <= 1'b0;
    end else begin
      if (push_req && full) ovf <= 1'b1;
      else if (reg_wr && (addr[3:2] == 2'd1) && wdata[3]) ovf <= 1'b0;
      if (reg_wr && (addr[3:2] == 2'd2))
        bauddiv <= (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
      if (reg_wr && (addr[3:2] == 2'd3)) begin
        tx_en  <= wdata[0];
        irq_en <= wdata[1];
      end
    end
  end

  // Frame byte and divisor are captured once per frame so later writes wait.
  always_ff @(posedge clk) begin
    if (pop) begin
      tx_byte   <= mem[rd_ptr];
      frame_div <= bauddiv;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      txd     <= 1'b1;
      bit_cnt <= 16'd1;
      bit_idx <= 3'd0;
    end else if (pop) begin
      state   <= START;
      txd     <= 1'b0;
      bit_cnt <= bauddiv;
    end else begin
      case (state)
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= 3'd0;
            txd     <= tx_byte[0];
            bit_cnt <= frame_div;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= frame_div;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= tx_byte[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) state <= IDLE;
          else         bit_cnt <= bit_cnt - 16'd1;
        end
        default: txd <= 1'b1;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr[3:2])
        2'd1:    rdata[7:0]  = {4'(count), ovf, busy, empty, full};
        2'd2:    rdata[15:0] = bauddiv;
        2'd3:    rdata[1:0]  = {irq_en, tx_en};
        default: rdata = '0;
      endcase
    end
  end
endmodule
